// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the IFU and the LSU.
// One transaction is outstanding at a time; a watchdog ends requests that never respond.
module pmem_arbiter #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            if_valid_i,
   output logic            if_ready_o,
   input  logic [AW-1:0]   if_addr_i,
   output logic            if_rvalid_o,
   output logic [DW-1:0]   if_rdata_o,
   output logic            if_err_o,
   input  logic            ls_valid_i,
   output logic            ls_ready_o,
   input  logic [AW-1:0]   ls_addr_i,
   input  logic            ls_wen_i,
   input  logic [DW-1:0]   ls_wdata_i,
   input  logic [DW/8-1:0] ls_wmask_i,
   output logic            ls_rvalid_o,
   output logic [DW-1:0]   ls_rdata_o,
   output logic            ls_err_o,
   output logic            mem_req_o,
   input  logic            mem_ready_i,
   output logic [AW-1:0]   mem_addr_o,
   output logic            mem_wen_o,
   output logic [DW-1:0]   mem_wdata_o,
   output logic [DW/8-1:0] mem_wmask_o,
   input  logic            mem_rvalid_i,
   input  logic [DW-1:0]   mem_rdata_i
);

   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e            state_q;
   logic              prio_ls_q;
   logic              owner_ls_q;
   logic [CW-1:0]     cnt_q;
   logic              mem_req_q;
   logic [AW-1:0]     addr_q;
   logic              wen_q;
   logic [DW-1:0]     wdata_q;
   logic [DW/8-1:0]   wmask_q;
   logic              if_rvalid_q, ls_rvalid_q;
   logic              if_err_q, ls_err_q;
   logic [DW-1:0]     if_rdata_q, ls_rdata_q;

   logic              gnt_if, gnt_ls;
   logic              timeout;
   logic [DW-1:0]     rsp_rdata;
   logic              rsp_err;

   // Grants are only offered in IDLE and never while reset is asserted.
   always_comb begin
      gnt_ls = 1'b0;
      gnt_if = 1'b0;
      if (state_q == StIdle && !rst_i) begin
         gnt_ls = ls_valid_i && (!if_valid_i || prio_ls_q);
         gnt_if = if_valid_i && !gnt_ls;
      end
   end

   // This WAIT cycle is the TIMEOUT-th one; a response in the same cycle still wins.
   assign timeout   = (cnt_q == CW'(TIMEOUT - 1));
   assign rsp_rdata = (mem_rvalid_i && !wen_q) ? mem_rdata_i : '0;
   assign rsp_err   = !mem_rvalid_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         prio_ls_q   <= 1'b1;
         owner_ls_q  <= 1'b0;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         addr_q      <= '0;
         wen_q       <= 1'b0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         if_err_q    <= 1'b0;
         ls_err_q    <= 1'b0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
      end else begin
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         if_err_q    <= 1'b0;
         ls_err_q    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (gnt_ls || gnt_if) begin
                  owner_ls_q <= gnt_ls;
                  prio_ls_q  <= gnt_if;
                  addr_q     <= gnt_ls ? ls_addr_i : if_addr_i;
                  wen_q      <= gnt_ls && ls_wen_i;
                  wdata_q    <= gnt_ls ? ls_wdata_i : '0;
                  wmask_q    <= gnt_ls ? ls_wmask_i : '0;
                  mem_req_q  <= 1'b1;
                  state_q    <= StIssue;
               end
            end
            StIssue: begin
               if (mem_ready_i) begin
                  mem_req_q <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= StWait;
               end
            end
            StWait: begin
               cnt_q <= cnt_q + CW'(1);
               if (mem_rvalid_i || timeout) begin
                  state_q <= StResp;
                  if (owner_ls_q) begin
                     ls_rvalid_q <= 1'b1;
                     ls_rdata_q  <= rsp_rdata;
                     ls_err_q    <= rsp_err;
                  end else begin
                     if_rvalid_q <= 1'b1;
                     if_rdata_q  <= rsp_rdata;
                     if_err_q    <= rsp_err;
                  end
               end
            end
            StResp: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign if_ready_o  = gnt_if;
   assign ls_ready_o  = gnt_ls;
   assign if_rvalid_o = if_rvalid_q;
   assign ls_rvalid_o = ls_rvalid_q;
   assign if_err_o    = if_err_q;
   assign ls_err_o    = ls_err_q;
   assign if_rdata_o  = if_rdata_q;
   assign ls_rdata_o  = ls_rdata_q;
   assign mem_req_o   = mem_req_q;
   assign mem_addr_o  = addr_q;
   assign mem_wen_o   = wen_q;
   assign mem_wdata_o = wdata_q;
   assign mem_wmask_o = wmask_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: a memory responder with tunable latency feeds a
// scoreboard of expected responses built from the requests the bench drives.
module tb_pmem_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_valid = 1'b0, if_ready, if_rvalid, if_err;
   logic [31:0] if_addr = '0, if_rdata;
   logic        ls_valid = 1'b0, ls_ready, ls_wen = 1'b0, ls_rvalid, ls_err;
   logic [31:0] ls_addr = '0, ls_wdata = '0, ls_rdata;
   logic [3:0]  ls_wmask = '0;
   logic        mem_req, mem_ready, mem_wen, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;

   typedef struct {
      logic        owner_ls;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   logic        gl[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   bit          busy = 1'b0;
   int          ready_delay = 0;
   int          resp_delay = 0;
   bit          no_resp = 1'b0;
   logic [31:0] x_addr = '0, x_wdata = '0;
   logic        x_wen = 1'b0;
   logic [3:0]  x_wmask = '0;

   pmem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .if_valid_i  (if_valid),
      .if_ready_o  (if_ready),
      .if_addr_i   (if_addr),
      .if_rvalid_o (if_rvalid),
      .if_rdata_o  (if_rdata),
      .if_err_o    (if_err),
      .ls_valid_i  (ls_valid),
      .ls_ready_o  (ls_ready),
      .ls_addr_i   (ls_addr),
      .ls_wen_i    (ls_wen),
      .ls_wdata_i  (ls_wdata),
      .ls_wmask_i  (ls_wmask),
      .ls_rvalid_o (ls_rvalid),
      .ls_rdata_o  (ls_rdata),
      .ls_err_o    (ls_err),
      .mem_req_o   (mem_req),
      .mem_ready_i (mem_ready),
      .mem_addr_o  (mem_addr),
      .mem_wen_o   (mem_wen),
      .mem_wdata_o (mem_wdata),
      .mem_wmask_o (mem_wmask),
      .mem_rvalid_i(mem_rvalid),
      .mem_rdata_i (mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      return (a == 32'h8000_0000) ? 32'h0000_0413 : ((a ^ 32'h5A5A_0F0F) + 32'd1);
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Memory wrapper model: mem_ready after ready_delay cycles of mem_req, then
   // mem_rvalid resp_delay cycles after the first WAIT cycle (never if no_resp).
   initial begin : responder
      int          rdy_wait;
      int          rsp_cnt;
      logic [31:0] la;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      rdy_wait = 0; rsp_cnt = 0; la = '0;
      forever begin
         @(posedge clk); #1;
         mem_ready  = 1'b0;
         mem_rvalid = 1'b0;
         if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0 && !no_resp) begin
               mem_rvalid = 1'b1;
               mem_rdata  = mem_model(la);
            end
         end else if (mem_req) begin
            if (rdy_wait > 0) rdy_wait--;
            else begin
               mem_ready = 1'b1;
               la        = mem_addr;
               rsp_cnt   = resp_delay + 1;
            end
         end else begin
            rdy_wait = ready_delay;
         end
      end
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst) begin
         if (if_ready && ls_ready) check_val("dual_ready", 1, 0);
         if (if_ready || ls_ready) begin
            check_val("grant_while_busy", busy, 0);
            e.owner_ls = ls_ready;
            x_addr     = ls_ready ? ls_addr : if_addr;
            x_wen      = ls_ready ? ls_wen : 1'b0;
            x_wmask    = ls_ready ? ls_wmask : 4'h0;
            x_wdata    = ls_wdata;
            e.err      = no_resp || (resp_delay >= TO);
            e.rdata    = (x_wen || e.err) ? 32'h0 : mem_model(x_addr);
            e.cyc      = e.err ? cyc + 2 + ready_delay + TO : cyc + 3 + ready_delay + resp_delay;
            sb.push_back(e);
            gl.push_back(ls_ready);
            busy = 1'b1;
         end
         if (mem_req) begin
            check_val("mem_fields", {mem_addr, mem_wen, mem_wmask}, {x_addr, x_wen, x_wmask});
            if (x_wen) check_val("mem_wdata", mem_wdata, x_wdata);
         end
         if (if_rvalid || ls_rvalid) begin
            if (sb.size() == 0) begin
               check_val("unexpected_rsp", {if_rvalid, ls_rvalid}, 2'b00);
            end else begin
               e = sb.pop_front();
               check_val("rsp_owner", {ls_rvalid, if_rvalid}, e.owner_ls ? 2'b10 : 2'b01);
               check_val("rsp_rdata", e.owner_ls ? ls_rdata : if_rdata, e.rdata);
               check_val("rsp_err", e.owner_ls ? ls_err : if_err, e.err);
               check_val("rsp_other_err", e.owner_ls ? if_err : ls_err, 0);
               check_val("rsp_cycle", cyc, e.cyc);
               busy = 1'b0;
            end
         end else begin
            check_val("err_idle", {if_err, ls_err}, 2'b00);
         end
      end
   end

   task automatic ifu_reqs(input int n, input logic [31:0] base);
      bit got;
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         if_addr  = base + 32'(4 * i);
         if_valid = 1'b1;
         got = 1'b0;
         for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = if_ready;
         end
         if (!got) check_val("if_ready_timeout", 0, 1);
         @(posedge clk); #1;
      end
      if_valid = 1'b0;
   endtask

   task automatic lsu_reqs(input int n, input logic [31:0] base, input logic wen,
                           input logic [31:0] wdata, input logic [3:0] wmask);
      bit got;
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         ls_addr  = base + 32'(4 * i);
         ls_wen   = wen;
         ls_wdata = wdata;
         ls_wmask = wmask;
         ls_valid = 1'b1;
         got = 1'b0;
         for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = ls_ready;
         end
         if (!got) check_val("ls_ready_timeout", 0, 1);
         @(posedge clk); #1;
      end
      ls_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 100 && (busy || sb.size() != 0); k++) @(negedge clk);
      check_val("rsp_timeout", busy || (sb.size() != 0), 0);
      repeat (2) @(posedge clk);
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_ctrl"}, {if_ready, ls_ready, if_rvalid, ls_rvalid, if_err, ls_err,
                                 mem_req, mem_wen, mem_wmask}, 0);
      check_val({tag, "_mem"}, {mem_addr, mem_wdata}, 0);
      check_val({tag, "_rdata"}, {if_rdata, ls_rdata}, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1; if_valid = 1'b0; ls_valid = 1'b0;
      sb.delete(); busy = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL global_timeout bench did not complete");
      $fatal(1, "global timeout");
   end

   initial begin : main
      #1 check_zero("reset");
      do_reset();

      // IFU only
      ifu_reqs(1, 32'h8000_0000);
      wait_idle();
      check_val("t1_rdata_hold", if_rdata, 32'h0000_0413);

      // simultaneous requests after reset: LSU first, then alternate
      do_reset();
      gl.delete();
      fork
         ifu_reqs(2, 32'h8000_0004);
         lsu_reqs(2, 32'h8000_2000, 1'b0, 32'h0, 4'h0);
      join
      wait_idle();
      check_val("t2_grants", gl.size(), 4);
      for (int i = 0; i < gl.size(); i++) check_val("t2_order", gl[i], (i % 2) == 0);

      // LSU write
      lsu_reqs(1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
      wait_idle();
      check_val("t3_rdata", ls_rdata, 0);

      // mem_ready backpressure with a competing request queued behind it
      ready_delay = 5;
      fork
         ifu_reqs(1, 32'h8000_0100);
         lsu_reqs(1, 32'h8000_3000, 1'b0, 32'h0, 4'h0);
      join
      wait_idle();
      ready_delay = 0;

      // watchdog: no response, response on the boundary, response one cycle late
      no_resp = 1'b1;
      lsu_reqs(1, 32'h8000_4000, 1'b0, 32'h0, 4'h0);
      wait_idle();
      no_resp = 1'b0;
      resp_delay = TO - 1;
      ifu_reqs(1, 32'h8000_0200);
      wait_idle();
      resp_delay = TO;
      ifu_reqs(1, 32'h8000_0300);
      wait_idle();
      check_val("t5_late_rdata", if_rdata, 0);

      // reset during WAIT, then a stray late mem_rvalid, then LSU priority restored
      resp_delay = 6;
      lsu_reqs(1, 32'h8000_5000, 1'b0, 32'h0, 4'h0);
      @(posedge clk); #3;
      rst = 1'b1;
      #1 check_zero("midrst");
      sb.delete(); busy = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (8) @(posedge clk);
      resp_delay = 0;
      gl.delete();
      fork
         ifu_reqs(1, 32'h8000_0400);
         lsu_reqs(1, 32'h8000_6000, 1'b0, 32'h0, 4'h0);
      join
      wait_idle();
      check_val("t6_grants", gl.size(), 2);
      if (gl.size() == 2) begin
         check_val("t6_first_lsu", gl[0], 1);
         check_val("t6_second_ifu", gl[1], 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
